harris_sequencer: RTL
=====================

HARRIS_SEQUENCER -- requirements
Module: harris_sequencer

Interface
REQ-001 SHALL have parameter COORD_BITS, default 11, width of row length, row count and coordinates.
REQ-002 SHALL have parameter SCORE_BITS, default 33, signed Harris score width.
REQ-003 SHALL have parameter PIPE_LATENCY, default 8, scorer advances from pixel input to score out, excluding line buffering.
REQ-004 SHALL have parameter ROW_DELAY, default 4, scorer row-buffer delay in rows.
REQ-005 SHALL have parameter BORDER, default 4, pixels suppressed at each image edge.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, begin frame (ignored unless IDLE).
REQ-009 SHALL have port r_row_length, input, COORD_BITS, pixels per row, latched at start.
REQ-010 SHALL have port r_num_rows, input, COORD_BITS, rows per frame, latched at start.
REQ-011 SHALL have port r_threshold, input, SCORE_BITS signed, latched at start.
REQ-012 SHALL have port pix_valid, input, 1, upstream pixel available.
REQ-013 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid and pix_ready are both high.
REQ-014 SHALL have port adv, output, 1, drives the scorer's in_valid (advance).
REQ-015 SHALL have port flush, output, 1, high during drain; scorer input mux selects zero luma.
REQ-016 SHALL have port score_in, input, SCORE_BITS signed, scorer out_score.
REQ-017 SHALL have ports corner_valid (out, 1), corner_ready (in, 1), corner_x and corner_y (out, COORD_BITS each), corner_score (out, SCORE_BITS): corner output handshake.
REQ-018 SHALL have port busy, output, 1, high when not IDLE; port frame_done, output, 1, one-cycle pulse.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-020 IDLE->RUN on start, latching registers and clearing counters; RUN->FLUSH after row_length*num_rows pixel accepts; FLUSH->DONE after D = ROW_DELAY*row_length + PIPE_LATENCY flush advances; DONE->IDLE in one cycle with frame_done high in DONE.
REQ-021 "stall" SHALL mean corner_valid high and corner_ready low.
REQ-022 In RUN, pix_ready SHALL equal not stall, and adv SHALL equal pix_valid and pix_ready.
REQ-023 In FLUSH, adv SHALL equal not stall, and flush SHALL be high; adv and flush SHALL be low in IDLE and DONE.
REQ-024 The advance counter A SHALL count total advances in the frame, RUN plus FLUSH, width sufficient for rows*row_length + D.
REQ-025 On the cycle after each advance with A >= D, score_in SHALL be sampled as the score for output pixel A-D; x/y counters SHALL step raster order, x wrapping at row_length.
REQ-026 A sampled pixel SHALL be a corner iff BORDER <= x < row_length-BORDER, BORDER <= y < num_rows-BORDER, and score_in > threshold (signed compare).
REQ-027 A corner SHALL load the output register (corner_valid=1, x, y, score) on the sample cycle; corner_valid SHALL clear on a handshake unless a new corner loads in the same cycle.
REQ-028 Back-to-back corners SHALL NOT be lost: the stall rule guarantees the register is free or draining before the next sample.
REQ-029 corner_x, corner_y and corner_score SHALL hold stable while corner_valid is high and corner_ready is low.
REQ-030 DONE SHALL NOT be entered while corner_valid is high; the FSM SHALL wait in FLUSH.
REQ-031 With row_length <= 2*BORDER or num_rows <= 2*BORDER, the frame SHALL complete with zero corners.
REQ-032 start while busy SHALL be ignored; register inputs SHALL be ignored outside IDLE.

Reset
REQ-033 reset, sampled on clk, SHALL return to IDLE, zero all counters, and drive corner_valid, pix_ready, adv, flush, busy and frame_done low, including mid-frame; other outputs SHALL be 0.

Structure
REQ-034 State enum and default BORDER/PIPE_LATENCY/ROW_DELAY constants SHALL reside in shared package harris_pkg.
REQ-035 One sub-module, raster_counter (x/y with wrap and frame-end flag), SHALL be used for both input and output coordinate counting.

Verification
REQ-036 8x8 frame, BORDER=2, threshold=-1, score_in=0 always, corner_ready=1 -> exactly 16 corners, (2,2) through (5,5) in raster order, then frame_done.
REQ-037 Same frame, threshold=0, score_in=0 -> zero corners; frame_done after exactly 64+4*8+8=104 advances.
REQ-038 corner_ready low for 10 cycles with a corner pending -> pix_ready and adv low for those cycles, corner fields stable, no corner lost.
REQ-039 pix_valid toggling 1/0 -> adv only on accepted pixels; corner sequence identical to REQ-036.
REQ-040 reset asserted at pixel 30 -> next cycle IDLE with all outputs low; a new start then runs a clean frame.
REQ-041 row_length=4, BORDER=2 -> no corners; frame_done still pulses once.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared types and defaults for the Harris corner sequencer.
package harris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int DEF_BORDER       = 4;
  localparam int DEF_PIPE_LATENCY = 8;
  localparam int DEF_ROW_DELAY    = 4;

  // True when border <= c < len - border, written without subtraction so a
  // short row or column simply yields no valid window.
  function automatic logic in_window(input logic [31:0] c,
                                     input logic [31:0] len,
                                     input logic [31:0] border);
    return (c >= border) && ((c + border) < len);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter with row wrap and end-of-frame flag.
module raster_counter #(
  parameter int COORD_BITS = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  input  logic [COORD_BITS-1:0] row_length,
  input  logic [COORD_BITS-1:0] num_rows,
  output logic [COORD_BITS-1:0] x,
  output logic [COORD_BITS-1:0] y,
  output logic                  last
);

  logic x_wrap;

  assign x_wrap = (x == row_length - COORD_BITS'(1));
  assign last   = x_wrap && (y == num_rows - COORD_BITS'(1));

  // Step one position per pulse; the final pixel of the frame wraps to origin.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_wrap) begin
        x <= '0;
        y <= last ? '0 : y + COORD_BITS'(1);
      end else begin
        x <= x + COORD_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/harris_sequencer.sv
// Frame sequencer for a streaming Harris scorer: paces pixels in, drains the
// scorer's row buffers, and emits thresholded corners through a handshake.
module harris_sequencer
  import harris_pkg::*;
#(
  parameter int COORD_BITS   = 11,
  parameter int SCORE_BITS   = 33,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int ROW_DELAY    = DEF_ROW_DELAY,
  parameter int BORDER       = DEF_BORDER
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic        [COORD_BITS-1:0] r_row_length,
  input  logic        [COORD_BITS-1:0] r_num_rows,
  input  logic signed [SCORE_BITS-1:0] r_threshold,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic                         adv,
  output logic                         flush,
  input  logic signed [SCORE_BITS-1:0] score_in,
  output logic                         corner_valid,
  input  logic                         corner_ready,
  output logic        [COORD_BITS-1:0] corner_x,
  output logic        [COORD_BITS-1:0] corner_y,
  output logic signed [SCORE_BITS-1:0] corner_score,
  output logic                         busy,
  output logic                         frame_done
);

  // Wide enough for rows*row_length plus the drain length.
  localparam int A_BITS = 2 * COORD_BITS + $clog2(ROW_DELAY + 2) + 1;

  state_t state, state_next;

  logic        [COORD_BITS-1:0] row_length, num_rows;
  logic signed [SCORE_BITS-1:0] threshold;
  logic        [A_BITS-1:0]     d_len, a_cnt, flush_cnt;
  logic                         sample_pending, out_done;

  logic stall, take_start, in_step, in_last, sample_fire, corner_hit, flush_room;
  logic [COORD_BITS-1:0] out_x, out_y;
  logic                  out_last;
  // The input side only needs the end-of-frame flag, not the position.
  logic [COORD_BITS-1:0] in_x_unused, in_y_unused;

  assign stall       = corner_valid && !corner_ready;
  assign take_start  = (state == ST_IDLE) && start;
  assign flush_room  = (flush_cnt != d_len);
  assign in_step     = (state == ST_RUN) && adv;
  // A score waits while the output register is blocked; the scorer does not
  // advance during a stall, so score_in holds until it is taken.
  assign sample_fire = sample_pending && !stall;
  assign corner_hit  = sample_fire
                    && in_window(32'(out_x), 32'(row_length), 32'(BORDER))
                    && in_window(32'(out_y), 32'(num_rows), 32'(BORDER))
                    && (score_in > threshold);

  raster_counter #(.COORD_BITS(COORD_BITS)) u_in_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (take_start),
    .step       (in_step),
    .row_length (row_length),
    .num_rows   (num_rows),
    .x          (in_x_unused),
    .y          (in_y_unused),
    .last       (in_last)
  );

  raster_counter #(.COORD_BITS(COORD_BITS)) u_out_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (take_start),
    .step       (sample_fire),
    .row_length (row_length),
    .num_rows   (num_rows),
    .x          (out_x),
    .y          (out_y),
    .last       (out_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; DONE waits until the last corner has been taken.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned and infers a latch.
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (in_step && in_last) state_next = ST_FLUSH;
      ST_FLUSH: if (out_done && !corner_valid) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    pix_ready  = 1'b0;
    adv        = 1'b0;
    flush      = 1'b0;
    frame_done = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_RUN: begin
        pix_ready = !stall;
        adv       = pix_valid && !stall;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        adv   = !stall && flush_room;
      end
      ST_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Frame configuration, advance/drain counters and score-sample tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_length     <= '0;
      num_rows       <= '0;
      threshold      <= '0;
      d_len          <= '0;
      a_cnt          <= '0;
      flush_cnt      <= '0;
      sample_pending <= 1'b0;
      out_done       <= 1'b0;
    end else if (take_start) begin
      row_length     <= r_row_length;
      num_rows       <= r_num_rows;
      threshold      <= r_threshold;
      d_len          <= A_BITS'(ROW_DELAY) * A_BITS'(r_row_length) + A_BITS'(PIPE_LATENCY);
      a_cnt          <= '0;
      flush_cnt      <= '0;
      sample_pending <= 1'b0;
      out_done       <= 1'b0;
    end else begin
      if (adv) begin
        a_cnt          <= a_cnt + A_BITS'(1);
        sample_pending <= (a_cnt >= d_len);
      end else if (sample_fire) begin
        sample_pending <= 1'b0;
      end
      if (adv && (state == ST_FLUSH)) flush_cnt <= flush_cnt + A_BITS'(1);
      if (sample_fire && out_last)    out_done  <= 1'b1;
    end
  end

  // Corner output register: loads on a hit, clears on handshake otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
      corner_score <= '0;
    end else if (corner_hit) begin
      corner_valid <= 1'b1;
      corner_x     <= out_x;
      corner_y     <= out_y;
      corner_score <= score_in;
    end else if (corner_valid && corner_ready) begin
      corner_valid <= 1'b0;
    end
  end

endmodule
